// File: rtl/lsu_pkg.sv
// lsu_pkg: funct3 codes, FSM states and access-size helper shared by the load/store unit
package lsu_pkg;
  typedef enum logic [2:0] {
    F3_LB  = 3'b000,
    F3_LH  = 3'b001,
    F3_LW  = 3'b010,
    F3_LD  = 3'b011,
    F3_LBU = 3'b100,
    F3_LHU = 3'b101,
    F3_LWU = 3'b110
  } f3_load_t;
  typedef enum logic [2:0] {
    F3_SB = 3'b000,
    F3_SH = 3'b001,
    F3_SW = 3'b010,
    F3_SD = 3'b011
  } f3_store_t;
  typedef enum logic [2:0] {IDLE, REQ0, WAIT0, REQ1, WAIT1, RESP} state_t;
  function automatic logic [3:0] size_bytes(input logic [2:0] funct3);
    return 4'd1 << funct3[1:0];
  endfunction
endpackage

// File: rtl/load_store_unit_if.sv
// load_store_unit_if: valid/ready data-memory bus
// master (unit): drives mem_req_valid/mem_we/mem_addr/mem_wdata/mem_wmask, receives ready and response
// slave (memory): the reverse
interface load_store_unit_if #(parameter int XLEN = 32, parameter int ADDR_W = 32);
  logic              mem_req_valid;
  logic              mem_req_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [XLEN-1:0]   mem_wdata;
  logic [XLEN/8-1:0] mem_wmask;
  logic              mem_rsp_valid;
  logic [XLEN-1:0]   mem_rdata;
  logic              mem_rsp_err;
  modport master (output mem_req_valid, mem_we, mem_addr, mem_wdata, mem_wmask,
                  input mem_req_ready, mem_rsp_valid, mem_rdata, mem_rsp_err);
  modport slave (input mem_req_valid, mem_we, mem_addr, mem_wdata, mem_wmask,
                 output mem_req_ready, mem_rsp_valid, mem_rdata, mem_rsp_err);
endinterface

// File: rtl/lsu_align.sv
// lsu_align: lane masks, lane-shifted store data and load extraction/extension for up to two beats
// in: off (byte offset in bus word), funct3, wdata, beat0/beat1 (captured read data)
// out: mask0/mask1, wdata0/wdata1 per beat, load_data (extended result)
module lsu_align import lsu_pkg::*; #(parameter int XLEN = 32) (
  input  logic [$clog2(XLEN/8)-1:0] off,
  input  logic [2:0]                funct3,
  input  logic [XLEN-1:0]           wdata,
  input  logic [XLEN-1:0]           beat0,
  input  logic [XLEN-1:0]           beat1,
  output logic [XLEN/8-1:0]         mask0,
  output logic [XLEN/8-1:0]         mask1,
  output logic [XLEN-1:0]           wdata0,
  output logic [XLEN-1:0]           wdata1,
  output logic [XLEN-1:0]           load_data
);
  localparam int B = XLEN / 8;
  logic [3:0]      size;
  logic [XLEN-1:0] raw, keep;
  logic            sign;
  assign size = size_bytes(funct3);
  // both beats are views of one double-width window; the upper half is the second beat
  assign {mask1, mask0} = (((2 * B)'(1) << size) - (2 * B)'(1)) << off;
  assign {wdata1, wdata0} = {{XLEN{1'b0}}, wdata} << {off, 3'b000};
  assign raw = XLEN'({beat1, beat0} >> {off, 3'b000});
  assign keep = ~({XLEN{1'b1}} << {size, 3'b000});
  // top kept bit is where keep has a 1 and keep>>1 has a 0
  assign sign = ~funct3[2] & |(raw & keep & ~(keep >> 1));
  assign load_data = (raw & keep) | ({XLEN{sign}} & ~keep);
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: multi-cycle load/store unit between execute stage and a valid/ready memory bus
// req_*: request from execute (held until req_ready); resp_*: one-cycle completion with data/error
// mem: bus master port; boundary-crossing accesses take two beats when MISALIGN_SPLIT=1
module load_store_unit import lsu_pkg::*; #(
  parameter int XLEN           = 32,
  parameter int ADDR_W         = 32,
  parameter int MISALIGN_SPLIT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_store,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  output logic              resp_valid,
  output logic [XLEN-1:0]   resp_data,
  output logic              resp_err,
  load_store_unit_if.master mem
);
  localparam int B     = XLEN / 8;
  localparam int OFF_W = $clog2(B);
  state_t            state, state_nx;
  logic              r_store, r_cross, r_err;
  logic [2:0]        r_f3;
  logic [ADDR_W-1:0] r_addr, base;
  logic [XLEN-1:0]   r_wdata, beat0, beat1, wdata0, wdata1, load_data;
  logic [B-1:0]      mask0, mask1;
  logic              cross_in, illegal_in, reject_in, hi;
  assign cross_in = (5'(req_addr[OFF_W-1:0]) + 5'(size_bytes(req_funct3))) > 5'(B);
  assign illegal_in = req_funct3 == 3'b111 ||
                      (XLEN == 32 && (req_funct3 == F3_LD || req_funct3 == F3_LWU));
  assign reject_in = illegal_in || (cross_in && MISALIGN_SPLIT == 0);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (req_valid) state_nx = reject_in ? RESP : REQ0;
      REQ0:    if (mem.mem_req_ready) state_nx = WAIT0;
      WAIT0:   if (mem.mem_rsp_valid) state_nx = (mem.mem_rsp_err || !r_cross) ? RESP : REQ1;
      REQ1:    if (mem.mem_req_ready) state_nx = WAIT1;
      WAIT1:   if (mem.mem_rsp_valid) state_nx = RESP;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_store <= 1'b0;
      r_cross <= 1'b0;
      r_err   <= 1'b0;
      r_f3    <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      beat0   <= '0;
      beat1   <= '0;
    end else begin
      if (state == IDLE && req_valid) begin
        r_store <= req_store;
        r_cross <= cross_in;
        r_err   <= reject_in;
        r_f3    <= req_funct3;
        r_addr  <= req_addr;
        r_wdata <= req_wdata;
        beat0   <= '0;
        beat1   <= '0;
      end
      if (state == WAIT0 && mem.mem_rsp_valid) begin
        beat0 <= mem.mem_rdata;
        r_err <= mem.mem_rsp_err;
      end
      if (state == WAIT1 && mem.mem_rsp_valid) begin
        beat1 <= mem.mem_rdata;
        r_err <= mem.mem_rsp_err;
      end
    end
  lsu_align #(.XLEN(XLEN)) u_align (
    .off       (r_addr[OFF_W-1:0]),
    .funct3    (r_f3),
    .wdata     (r_wdata),
    .beat0     (beat0),
    .beat1     (beat1),
    .mask0     (mask0),
    .mask1     (mask1),
    .wdata0    (wdata0),
    .wdata1    (wdata1),
    .load_data (load_data)
  );
  assign hi = state == REQ1;
  assign base = {r_addr[ADDR_W-1:OFF_W], OFF_W'(0)};
  assign mem.mem_req_valid = state == REQ0 || state == REQ1;
  assign mem.mem_we = mem.mem_req_valid & r_store;
  assign mem.mem_addr = mem.mem_req_valid ? base + (hi ? ADDR_W'(B) : '0) : '0;
  assign mem.mem_wmask = mem.mem_req_valid ? (hi ? mask1 : mask0) : '0;
  assign mem.mem_wdata = mem.mem_req_valid ? (hi ? wdata1 : wdata0) : '0;
  assign req_ready = state == IDLE;
  assign resp_valid = state == RESP;
  assign resp_err = resp_valid & r_err;
  assign resp_data = (resp_valid && !r_err && !r_store) ? load_data : '0;
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed and randomized checks of three unit configurations against a byte-array model
module tb_load_store_unit;
  import lsu_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  logic [2:0]  rv = '0;
  logic        r_store = 1'b0;
  logic [2:0]  r_f3 = '0;
  logic [31:0] r_addr = '0;
  logic [63:0] r_wdata = '0;
  logic        a_ready = 1'b1;
  logic        a_rdy, a_rv, a_err, b_rdy, b_rv, b_err, c_rdy, c_rv, c_err;
  logic [31:0] a_data, b_data;
  logic [63:0] c_data;
  load_store_unit_if #(.XLEN(32), .ADDR_W(32)) a_bus ();
  load_store_unit_if #(.XLEN(32), .ADDR_W(32)) b_bus ();
  load_store_unit_if #(.XLEN(64), .ADDR_W(32)) c_bus ();
  load_store_unit #(.XLEN(32), .ADDR_W(32), .MISALIGN_SPLIT(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .req_valid(rv[0]), .req_ready(a_rdy), .req_store(r_store),
    .req_funct3(r_f3), .req_addr(r_addr), .req_wdata(r_wdata[31:0]), .resp_valid(a_rv),
    .resp_data(a_data), .resp_err(a_err), .mem(a_bus.master));
  load_store_unit #(.XLEN(32), .ADDR_W(32), .MISALIGN_SPLIT(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .req_valid(rv[1]), .req_ready(b_rdy), .req_store(r_store),
    .req_funct3(r_f3), .req_addr(r_addr), .req_wdata(r_wdata[31:0]), .resp_valid(b_rv),
    .resp_data(b_data), .resp_err(b_err), .mem(b_bus.master));
  load_store_unit #(.XLEN(64), .ADDR_W(32), .MISALIGN_SPLIT(1)) dut_c (
    .clk(clk), .rst_n(rst_n), .req_valid(rv[2]), .req_ready(c_rdy), .req_store(r_store),
    .req_funct3(r_f3), .req_addr(r_addr), .req_wdata(r_wdata), .resp_valid(c_rv),
    .resp_data(c_data), .resp_err(c_err), .mem(c_bus.master));

  function automatic logic [7:0] init_byte(input int i);
    return 8'(i * 37 + 11);
  endfunction

  // bus memory behind dut_a; not affected by rst_n so late responses still arrive
  logic [7:0] a_mem [512];
  bit a_init = 1'b0;
  int a_cnt = 0;
  int a_lat = 0;
  bit inject_err = 1'b0;
  assign a_bus.mem_req_ready = a_ready;
  always @(posedge clk) begin
    a_bus.mem_rsp_valid <= 1'b0;
    if (!a_init) begin
      for (int i = 0; i < 512; i++) a_mem[i] <= init_byte(i);
      a_init <= 1'b1;
    end else if (a_cnt > 0) begin
      a_cnt <= a_cnt - 1;
      if (a_cnt == 1) a_bus.mem_rsp_valid <= 1'b1;
    end else if (a_bus.mem_req_valid && a_bus.mem_req_ready) begin
      for (int i = 0; i < 4; i++) begin
        a_bus.mem_rdata[8*i +: 8] <= a_mem[9'(a_bus.mem_addr + 32'(i))];
        if (a_bus.mem_we && a_bus.mem_wmask[i]) a_mem[9'(a_bus.mem_addr + 32'(i))] <= a_bus.mem_wdata[8*i +: 8];
      end
      a_bus.mem_rsp_err <= inject_err;
      if (a_lat == 0) a_bus.mem_rsp_valid <= 1'b1;
      else a_cnt <= a_lat;
    end
  end
  // fixed-data zero-wait responders for the other two units
  assign b_bus.mem_req_ready = 1'b1;
  assign c_bus.mem_req_ready = 1'b1;
  always @(posedge clk) begin
    b_bus.mem_rsp_valid <= b_bus.mem_req_valid;
    b_bus.mem_rdata <= 32'h12345678;
    b_bus.mem_rsp_err <= 1'b0;
    c_bus.mem_rsp_valid <= c_bus.mem_req_valid;
    c_bus.mem_rdata <= 64'h8877665544332211;
    c_bus.mem_rsp_err <= 1'b0;
  end

  int sel = 0;
  logic        o_rdy, o_rv, o_err, o_mv, o_mwe;
  logic [63:0] o_data, o_mwd;
  logic [31:0] o_maddr;
  logic [7:0]  o_mask;
  assign o_rdy = sel == 0 ? a_rdy : sel == 1 ? b_rdy : c_rdy;
  assign o_rv = sel == 0 ? a_rv : sel == 1 ? b_rv : c_rv;
  assign o_err = sel == 0 ? a_err : sel == 1 ? b_err : c_err;
  assign o_data = sel == 0 ? 64'(a_data) : sel == 1 ? 64'(b_data) : c_data;
  assign o_mv = sel == 0 ? a_bus.mem_req_valid : sel == 1 ? b_bus.mem_req_valid : c_bus.mem_req_valid;
  assign o_mwe = sel == 0 ? a_bus.mem_we : sel == 1 ? b_bus.mem_we : c_bus.mem_we;
  assign o_maddr = sel == 0 ? a_bus.mem_addr : sel == 1 ? b_bus.mem_addr : c_bus.mem_addr;
  assign o_mask = sel == 0 ? 8'(a_bus.mem_wmask) : sel == 1 ? 8'(b_bus.mem_wmask) : c_bus.mem_wmask;
  assign o_mwd = sel == 0 ? 64'(a_bus.mem_wdata) : sel == 1 ? 64'(b_bus.mem_wdata) : c_bus.mem_wdata;

  int checks = 0;
  int failures = 0;
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  logic [7:0] ref_mem [512];
  function automatic logic [63:0] ref_load(input logic [2:0] f3, input int ad, input int xlen);
    int sz = 1 << f3[1:0];
    logic [63:0] v = '0;
    for (int i = 0; i < sz; i++) v[8*i +: 8] = ref_mem[(ad + i) % 512];
    if (!f3[2] && v[8*sz-1]) v = v | ~((64'd1 << (8 * sz)) - 64'd1);
    return xlen == 32 ? 64'(v[31:0]) : v;
  endfunction

  int cyc, nb;
  logic [63:0] rdat;
  logic rerr, rdy1;
  logic [31:0] bq_addr [2];
  logic [7:0]  bq_mask [2];
  logic [63:0] bq_wd [2];
  logic        bq_we [2];

  // one request to unit d; mode (unit a only): 0 ready always, 1 random ready, 2 ready low for the first 3 cycles
  task automatic run(input int d, input logic st, input logic [2:0] f3, input logic [31:0] ad,
                     input logic [63:0] wd, input int mode);
    logic done, held, rdy;
    logic [104:0] snap;
    sel = d;
    @(negedge clk);
    rv[d] = 1'b1;
    r_store = st;
    r_f3 = f3;
    r_addr = ad;
    r_wdata = wd;
    @(posedge clk);
    cyc = 0; nb = 0; rdat = '0; rerr = 1'b0; done = 1'b0; held = 1'b0; snap = '0; rdy1 = 1'b1;
    for (int k = 0; k < 200 && !done; k++) begin
      @(negedge clk);
      rv = '0;
      cyc++;
      if (cyc == 1) rdy1 = o_rdy;
      if (o_rv) begin
        rdat = o_data;
        rerr = o_err;
        done = 1'b1;
      end else begin
        if (d == 0) a_ready = mode == 0 ? 1'b1 : mode == 1 ? ($urandom_range(0, 2) != 0) : (cyc > 3);
        rdy = d == 0 ? a_ready : 1'b1;
        if (o_mv) begin
          if (held) chk("bus_hold", {o_maddr, o_mask, o_mwd, o_mwe}, snap);
          snap = {o_maddr, o_mask, o_mwd, o_mwe};
          held = !rdy;
          if (rdy) begin
            if (nb < 2) begin
              bq_addr[nb] = o_maddr;
              bq_mask[nb] = o_mask;
              bq_wd[nb] = o_mwd;
              bq_we[nb] = o_mwe;
            end
            nb++;
          end
        end else held = 1'b0;
      end
    end
    a_ready = 1'b1;
    chk("resp_arrived", done, 1'b1);
  endtask

  // unit a request checked against the byte-array model, which is then updated for legal stores
  task automatic a_op(input logic st, input logic [2:0] f3, input logic [31:0] ad, input logic [31:0] wd, input int mode);
    int sz = 1 << f3[1:0];
    int off = int'(ad % 4);
    logic ill = f3 == 3'b111 || f3 == 3'b011 || f3 == 3'b110;
    int exp_nb = ill ? 0 : (off + sz > 4 ? 2 : 1);
    logic [63:0] exp_data = (st || ill) ? 64'd0 : ref_load(f3, int'(ad % 512), 32);
    run(0, st, f3, ad, 64'(wd), mode);
    chk("a_err", rerr, ill);
    chk("a_data", rdat, exp_data);
    chk("a_beats", nb, exp_nb);
    if (st && !ill) for (int i = 0; i < sz; i++) ref_mem[(int'(ad % 512) + i) % 512] = wd[8*i +: 8];
  endtask

  initial begin
    logic late;
    logic st;
    logic [2:0] f3;
    logic [2:0] ld_f3 [8];
    ld_f3 = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b011, 3'b110, 3'b111};
    for (int i = 0; i < 512; i++) ref_mem[i] = init_byte(i);
    repeat (3) @(negedge clk);
    chk("rst_req_ready", o_rdy, 1'b1);
    chk("rst_resp_valid", o_rv, 1'b0);
    chk("rst_mem_valid", o_mv, 1'b0);
    chk("rst_resp_data", o_data, 64'd0);
    chk("rst_mem_addr", o_maddr, 32'd0);
    rst_n = 1'b1;
    a_op(1'b1, F3_SW, 32'h100, 32'hDEADBEEF, 0);
    chk("sw_busy", rdy1, 1'b0);
    chk("sw_lat", cyc, 3);
    chk("sw_addr", bq_addr[0], 32'h100);
    chk("sw_mask", bq_mask[0], 8'hF);
    chk("sw_wdata", bq_wd[0], 64'hDEADBEEF);
    chk("sw_we", bq_we[0], 1'b1);
    a_op(1'b1, F3_SW, 32'h100, 32'h80017FFF, 0);
    a_op(1'b0, F3_LH, 32'h102, 32'h0, 0);
    chk("lh_data", rdat, 64'hFFFF8001);
    chk("lh_lat", cyc, 3);
    a_op(1'b0, F3_LHU, 32'h102, 32'h0, 0);
    chk("lhu_data", rdat, 64'h00008001);
    a_op(1'b0, F3_LB, 32'h101, 32'h0, 0);
    chk("lb_data", rdat, 64'h7F);
    a_op(1'b1, F3_SW, 32'h103, 32'h11223344, 0);
    chk("split_sw_lat", cyc, 5);
    chk("split_b0_addr", bq_addr[0], 32'h100);
    chk("split_b0_mask", bq_mask[0], 8'h8);
    chk("split_b0_wdata", bq_wd[0], 64'h44000000);
    chk("split_b1_addr", bq_addr[1], 32'h104);
    chk("split_b1_mask", bq_mask[1], 8'h7);
    chk("split_b1_wdata", bq_wd[1], 64'h00112233);
    a_op(1'b1, F3_SW, 32'h100, 32'hAABBCCDD, 0);
    a_op(1'b1, F3_SW, 32'h104, 32'h11223344, 0);
    a_op(1'b0, F3_LW, 32'h102, 32'h0, 2);
    chk("split_lw_data", rdat, 64'h3344AABB);
    chk("split_lw_stall_lat", cyc, 8);
    a_op(1'b0, F3_LD, 32'h100, 32'h0, 0);
    chk("ld32_lat", cyc, 1);
    inject_err = 1'b1;
    run(0, 1'b0, F3_LW, 32'h102, 64'h0, 0);
    inject_err = 1'b0;
    chk("buserr_err", rerr, 1'b1);
    chk("buserr_data", rdat, 64'd0);
    chk("buserr_beats", nb, 1);
    // reset while waiting for the first response; the response arrives after reset and must be ignored
    a_lat = 4;
    sel = 0;
    @(negedge clk);
    rv[0] = 1'b1; r_store = 1'b0; r_f3 = F3_LW; r_addr = 32'h100;
    @(posedge clk);
    @(negedge clk);
    rv = '0;
    chk("rst_mid_req", o_mv, 1'b1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_ready", o_rdy, 1'b1);
    chk("rst_mid_mem_valid", o_mv, 1'b0);
    chk("rst_mid_resp_valid", o_rv, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    late = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (o_rv) late = 1'b1;
    end
    chk("late_rsp_ignored", late, 1'b0);
    a_lat = 0;
    a_op(1'b0, F3_LW, 32'h100, 32'h0, 0);
    chk("after_rst_lw", rdat, 64'hAABBCCDD);
    for (int n = 0; n < 80; n++) begin
      st = 1'($urandom_range(0, 1));
      f3 = st ? 3'($urandom_range(0, 3)) : ld_f3[$urandom_range(0, 7)];
      a_op(st, f3, 32'($urandom_range(0, 511)), $urandom, 1);
    end
    run(1, 1'b0, F3_LW, 32'h101, 64'h0, 0);
    chk("nosplit_err", rerr, 1'b1);
    chk("nosplit_lat", cyc, 1);
    chk("nosplit_beats", nb, 0);
    run(1, 1'b0, F3_LH, 32'h102, 64'h0, 0);
    chk("nosplit_lh_err", rerr, 1'b0);
    chk("nosplit_lh_data", rdat, 64'h1234);
    run(1, 1'b0, F3_LB, 32'h103, 64'h0, 0);
    chk("nosplit_lb_data", rdat, 64'h12);
    run(2, 1'b0, F3_LD, 32'h8, 64'h0, 0);
    chk("x64_ld_data", rdat, 64'h8877665544332211);
    chk("x64_ld_lat", cyc, 3);
    chk("x64_ld_beats", nb, 1);
    chk("x64_ld_addr", bq_addr[0], 32'h8);
    run(2, 1'b0, F3_LB, 32'hF, 64'h0, 0);
    chk("x64_lb_data", rdat, 64'hFFFFFFFFFFFFFF88);
    run(2, 1'b1, F3_SD, 32'h10, 64'h0123456789ABCDEF, 0);
    chk("x64_sd_mask", bq_mask[0], 8'hFF);
    chk("x64_sd_wdata", bq_wd[0], 64'h0123456789ABCDEF);
    chk("x64_sd_resp", rdat, 64'd0);
    run(2, 1'b0, F3_LW, 32'h6, 64'h0, 0);
    chk("x64_split_data", rdat, 64'h22118877);
    chk("x64_split_lat", cyc, 5);
    chk("x64_split_b1_addr", bq_addr[1], 32'h8);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
